ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
// - PS/2 host-to-device transmitter, the send path complementing the keyboard receiver (kbd).
// - Sends command bytes to the keyboard, e.g. 0xED set-LEDs or 0xFF reset, from the I-CPU port space.
// - Drives the open-drain PS/2 clock/data pads; the top level wires pad = drive_low ? 1'b0 : 1'bz.
// - Asserts rx_inhibit so the receiver ignores edges while a frame is being sent.
// PARAMETERS
// - INHIBIT_CYCLES  5000    clk cycles to hold PS/2 clock low before the request (100 us at 50 MHz)
// - SETUP_CYCLES    16      clk cycles with clock and data both low before clock is released
// - TIMEOUT_CYCLES  750000  max clk cycles from clock release to ack sample (15 ms); counter width $clog2 of this
// PORTS
// - clk            in   1  system clock, 50 MHz
// - reset          in   1  synchronous, active-high
// - stb            in   1  one-cycle access strobe from the CPU port decode
// - we             in   1  1 = write command byte; 0 = status read
// - data_in        in   8  command byte, sampled when stb & we
// - data_out       out  8  status {5'd0, error, done, busy}; combinational from the registered flags
// - ps2_clk_in     in   1  PS/2 clock pad level (asynchronous)
// - ps2_data_in    in   1  PS/2 data pad level (asynchronous)
// - ps2_clk_low    out  1  1 = pull PS/2 clock low
// - ps2_data_low   out  1  1 = pull PS/2 data low
// - rx_inhibit     out  1  1 while state != IDLE
// BEHAVIOUR
// - Reset values:
//   - all outputs 0, state IDLE, flags cleared.
//   - Reset mid-frame releases both lines on the next edge.
// - Pad inputs: 2-flop synchronizer plus previous-value flop.
//   - fall = prev & ~cur, one clk pulse per falling clock edge.
//   - Sync latency: 2 cycles.
// - Start:
//   - stb & we in IDLE latches data_in and computes parity = ~^data_in (odd).
//   - Clears done and error, sets busy, goes to INHIBIT on the next cycle.
//   - stb & we while busy is ignored; byte is dropped, no flag change.
//   - A read (stb & ~we) has no side effects.
// - States and transitions:
//   - IDLE: both lines released.
//   - INHIBIT: ps2_clk_low=1 for exactly INHIBIT_CYCLES cycles -> SETUP.
//   - SETUP: clk_low=1, data_low=1 (start bit) for SETUP_CYCLES cycles -> SEND.
//     - Release clk_low; start the timeout counter; bit index=0.
//   - SEND: on each fall, drive the next bit (ps2_data_low = ~bit).
//     - Order: data[0..7], then parity.
//     - Drive changes in the cycle after fall.
//     - After the parity bit is driven, the next fall releases data (stop bit = 1) -> ACK.
//   - ACK: on the next fall, sample synchronized data.
//     - 0 -> WAIT_IDLE.
//     - 1 -> error=1 -> WAIT_IDLE.
//   - WAIT_IDLE: wait until synchronized clock and data are both high -> IDLE.
//     - busy=0 and done=1 in that same cycle.
// - Timeout:
//   - Counter runs from clock release through WAIT_IDLE.
//   - Reaching TIMEOUT_CYCLES in any of those states releases both lines, sets error=1 and done=1, clears busy, goes IDLE.
//   - Covers an absent keyboard (no clock edges).
// - Fall events outside SEND/ACK are ignored.
// - done and error are sticky until the next accepted write or reset.
// STRUCTURE
// - ps2_pkg (shared with kbd):
//   - state encoding localparams: IDLE, INHIBIT, SETUP, SEND, ACK, WAIT_IDLE;
//   - frame constants: DATA_BITS=8, FRAME_BITS=11;
//   - status bit indices: BUSY=0, DONE=1, ERROR=2.
// - Sub-module ps2_edge_sync: synchronizer plus falling-edge detect per line.
//   - Instantiated for clock and data; reusable by kbd.
// - Top-level hookup:
//   - I-CPU port decode: stb = (read|write strobe) & portId bit;
//   - data_out is muxed into icpuReadData.
// TESTING
// Device model: BFM generates a 12.5 kHz device clock after seeing the request, samples data on rising edges, acks on the 11th falling edge.
// - Write 0xED -> see below.
//   - clk_low is high for exactly 5000 cycles, then data_low+clk_low for 16 cycles.
//   - BFM captures bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
//   - After ack: status 0x02.
// - Write 0x07 -> parity bit 0 captured; write 0x00 -> parity 1.
//   - Both end with done=1, error=0.
// - BFM leaves data high at the ack edge -> status 0x06 (done|error); lines released.
// - No device, clock never toggles -> see below.
//   - After the 750000-cycle timeout, status 0x06 and both drive outputs 0.
//   - rx_inhibit deasserts.
// - Second write mid-frame (0xFF during SEND of 0xED) -> see below.
//   - Frame continues as 0xED unchanged.
//   - No second frame follows.
// - Reset asserted during SEND -> see below.
//   - Next cycle: ps2_clk_low=0, ps2_data_low=0, status 0x00.
//   - A new write then sends a complete, correct frame.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encoding, frame constants and status bit positions
package ps2_pkg;

    typedef logic [2:0] ps2_state_t;

    localparam ps2_state_t IDLE      = 3'd0;
    localparam ps2_state_t INHIBIT   = 3'd1;
    localparam ps2_state_t SETUP     = 3'd2;
    localparam ps2_state_t SEND      = 3'd3;
    localparam ps2_state_t ACK       = 3'd4;
    localparam ps2_state_t WAIT_IDLE = 3'd5;

    // start + 8 data + parity + stop
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;

    // status register bit positions
    localparam int BUSY  = 0;
    localparam int DONE  = 1;
    localparam int ERROR = 2;

    // odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_edge_sync.sv
// rtl/ps2_host_tx_edge_sync.sv - two-flop pad synchronizer with falling-edge pulse
module ps2_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic pad_in,
    output logic level,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // shift the pad level through the synchronizer and keep the previous synced value
    always_comb begin
        meta_d = pad_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // released PS/2 lines idle high, so reset to 1 to avoid a false edge out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with status port
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stb,
    input  logic                 we,
    input  logic [DATA_BITS-1:0] data_in,
    output logic [7:0]           data_out,
    input  logic                 ps2_clk_in,
    input  logic                 ps2_data_in,
    output logic                 ps2_clk_low,
    output logic                 ps2_data_low,
    output logic                 rx_inhibit
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    // index reached once data and parity have all been driven; next fall is the stop bit
    localparam logic [3:0]       STOP_IDX   = 4'(FRAME_BITS - 2);

    ps2_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [DATA_BITS:0]   frame_q, frame_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 drv_q, drv_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic                 clk_sync, clk_fall;
    logic                 data_sync, unused_data_fall;

    ps2_edge_sync u_clk_sync (
        .clk    (clk),
        .reset  (reset),
        .pad_in (ps2_clk_in),
        .level  (clk_sync),
        .fall   (clk_fall)
    );

    ps2_edge_sync u_data_sync (
        .clk    (clk),
        .reset  (reset),
        .pad_in (ps2_data_in),
        .level  (data_sync),
        .fall   (unused_data_fall)
    );

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            to_cnt_q  <= '0;
            frame_q   <= '0;
            bit_idx_q <= '0;
            drv_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            to_cnt_q  <= to_cnt_d;
            frame_q   <= frame_d;
            bit_idx_q <= bit_idx_d;
            drv_q     <= drv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // next-state: request phases, bit shifting on device clock falls, ack and timeout
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        to_cnt_d  = to_cnt_q;
        frame_d   = frame_q;
        bit_idx_d = bit_idx_q;
        drv_d     = drv_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;

        case (state_q)
            IDLE: begin
                if (stb && we) begin
                    frame_d = {odd_parity(data_in), data_in};
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    cnt_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    state_d = SETUP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d     = '0;
                    to_cnt_d  = '0;
                    bit_idx_d = '0;
                    drv_d     = 1'b1;
                    state_d   = SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (clk_fall) begin
                    if (bit_idx_q == STOP_IDX) begin
                        drv_d   = 1'b0;
                        state_d = ACK;
                    end else begin
                        drv_d     = ~frame_q[bit_idx_q];
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    if (data_sync) begin
                        error_d = 1'b1;
                    end
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // device must finish within the window that opens when the clock is released
        if (state_q == SEND || state_q == ACK || state_q == WAIT_IDLE) begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (to_cnt_q == TO_LAST) begin
                drv_d   = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                error_d = 1'b1;
                state_d = IDLE;
            end
        end
    end

    // pad drive outputs decoded from the current state
    always_comb begin
        ps2_clk_low  = 1'b0;
        ps2_data_low = 1'b0;
        case (state_q)
            INHIBIT: begin
                ps2_clk_low = 1'b1;
            end
            SETUP: begin
                ps2_clk_low  = 1'b1;
                ps2_data_low = 1'b1;
            end
            SEND: begin
                ps2_data_low = drv_q;
            end
            default: begin
                ps2_clk_low  = 1'b0;
                ps2_data_low = 1'b0;
            end
        endcase
    end

    // status word read by the CPU
    always_comb begin
        data_out        = '0;
        data_out[BUSY]  = busy_q;
        data_out[DONE]  = done_q;
        data_out[ERROR] = error_q;
    end

    assign rx_inhibit = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized self-checking bench with a PS/2 device model
module tb_ps2_host_tx;

    localparam int INH = 300;
    localparam int SET = 16;
    localparam int TO  = 3000;
    localparam int HP  = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       stb;
    logic       we;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       ps2_clk_low;
    logic       ps2_data_low;
    logic       rx_inhibit;
    logic       dev_clk_low;
    logic       dev_data_low;
    logic       ps2_clk_pad;
    logic       ps2_data_pad;

    int n_checks = 0;
    int n_fail   = 0;

    assign ps2_clk_pad  = ~(ps2_clk_low | dev_clk_low);
    assign ps2_data_pad = ~(ps2_data_low | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .SETUP_CYCLES   (SET),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stb          (stb),
        .we           (we),
        .data_in      (data_in),
        .data_out     (data_out),
        .ps2_clk_in   (ps2_clk_pad),
        .ps2_data_in  (ps2_data_pad),
        .ps2_clk_low  (ps2_clk_low),
        .ps2_data_low (ps2_data_low),
        .rx_inhibit   (rx_inhibit)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // frame as seen on the wire, index 0 = start bit
    function automatic logic [10:0] expected_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic cpu_write(input logic [7:0] b);
        @(negedge clk);
        stb = 1'b1; we = 1'b1; data_in = b;
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic cpu_read(output logic [7:0] s);
        @(negedge clk);
        stb = 1'b1; we = 1'b0; data_in = 8'hA5;
        @(negedge clk);
        stb = 1'b0;
        s = data_out;
    endtask

    // measures the clock-inhibit and start-bit setup phases of a request
    task automatic measure_request();
        int cnt;
        cnt = 0;
        while (ps2_clk_low && !ps2_data_low && cnt < INH + 50) begin
            cnt++;
            @(negedge clk);
        end
        check("inhibit_len", cnt, INH);
        cnt = 0;
        while (ps2_clk_low && ps2_data_low && cnt < SET + 50) begin
            cnt++;
            @(negedge clk);
        end
        check("setup_len", cnt, SET);
        check("clk_released", ps2_clk_low, 1'b0);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit do_ack, input int inject_k, input int reset_k);
        logic [10:0] cap;
        logic [7:0]  s;
        int          cnt;
        cap = '0;
        cpu_write(b);
        check("busy_after_write", data_out, 8'h01);
        check("rx_inhibit_on", rx_inhibit, 1'b1);
        measure_request();
        tick(HP);
        cap[0] = ps2_data_pad;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && do_ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            if (k == inject_k) begin
                cpu_write(8'hFF);
                check("busy_after_drop", data_out, 8'h01);
                tick(HP - 2);
            end else if (k == reset_k) begin
                tick(HP / 2);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("rst_clk_low", ps2_clk_low, 1'b0);
                check("rst_data_low", ps2_data_low, 1'b0);
                check("rst_status", data_out, 8'h00);
                check("rst_rx_inhibit", rx_inhibit, 1'b0);
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
                tick(HP);
                return;
            end else begin
                tick(HP);
            end
            dev_clk_low = 1'b0;
            tick(HP / 2);
            if (k <= 10) cap[k] = ps2_data_pad;
            else dev_data_low = 1'b0;
            tick(HP - HP / 2);
        end
        cnt = 0;
        while (rx_inhibit && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        check("frame_ends", rx_inhibit, 1'b0);
        check("frame_bits", cap, expected_frame(b));
        check("status_after", data_out, do_ack ? 8'h02 : 8'h06);
        check("lines_released", {ps2_clk_low, ps2_data_low}, 2'b00);
        cpu_read(s);
        check("status_read", s, do_ack ? 8'h02 : 8'h06);
    endtask

    initial begin
        logic [7:0] s;
        int         cnt;
        reset = 1'b1; stb = 1'b0; we = 1'b0; data_in = '0;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        tick(3);
        check("reset_status", data_out, 8'h00);
        check("reset_drive", {ps2_clk_low, ps2_data_low}, 2'b00);
        check("reset_rx_inhibit", rx_inhibit, 1'b0);
        reset = 1'b0;
        tick(5);
        cpu_read(s);
        check("idle_read", s, 8'h00);
        check("read_no_start", rx_inhibit, 1'b0);

        run_frame(8'hED, 1'b1, 0, 0);
        run_frame(8'h07, 1'b1, 0, 0);
        run_frame(8'h00, 1'b1, 0, 0);
        run_frame(8'hED, 1'b0, 0, 0);
        tick(20);
        check("error_sticky", data_out, 8'h06);

        run_frame(8'hED, 1'b1, 3, 0);
        cnt = 0;
        repeat (2 * INH) begin
            @(negedge clk);
            if (ps2_clk_low || rx_inhibit) cnt++;
        end
        check("no_second_frame", cnt, 0);
        check("status_after_drop", data_out, 8'h02);

        run_frame(8'hED, 1'b1, 0, 4);
        tick(10);
        run_frame(8'($urandom), 1'b1, 0, 0);

        for (int i = 0; i < 6; i++) begin
            run_frame(8'($urandom), ($urandom_range(0, 3) != 0), 0, 0);
        end

        cpu_write(8'($urandom));
        measure_request();
        cnt = 0;
        while (rx_inhibit && cnt < TO + 100) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_len", cnt, TO);
        check("timeout_status", data_out, 8'h06);
        check("timeout_drive", {ps2_clk_low, ps2_data_low}, 2'b00);
        check("timeout_rx_inhibit", rx_inhibit, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
